tl_requester: RTL and testbench
===============================

TL_REQUESTER -- requirements
Module: tl_requester

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, max cycles WAIT may last before a timeout is reported (legal range 2..65535).
REQ-002 SHALL have ports: clock  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have: cmd_valid in 1, cmd_ready out 1, cmd_opcode in 3, cmd_address in 128, cmd_size in 2; these form the command handshake.
REQ-005 SHALL have: auto_out_a_valid out 1, auto_out_a_ready in 1, auto_out_a_bits_opcode out 3, auto_out_a_bits_size out 2, auto_out_a_bits_address out 128; this is the TileLink A channel.
REQ-006 SHALL have: auto_out_d_valid in 1, auto_out_d_ready out 1, auto_out_d_bits_opcode in 3, _param in 2, _size in 2, _denied in 1, _corrupt in 1; this is the TileLink D channel.
REQ-007 SHALL have: rsp_valid out 1, rsp_ready in 1, rsp_opcode out 3, rsp_denied out 1, rsp_corrupt out 1, rsp_mismatch out 1, rsp_timeout out 1; this is the result handshake.

Function
REQ-008 SHALL implement FSM IDLE -> REQ -> WAIT -> RSP -> IDLE, with exactly one transaction outstanding.
REQ-009 cmd_ready SHALL be 1 only in IDLE; cmd_valid&cmd_ready SHALL capture opcode/address/size and enter REQ on the next cycle.
REQ-010 In REQ, auto_out_a_valid SHALL be 1 and A bits SHALL equal the captured values, held stable until auto_out_a_ready; the A fire SHALL enter WAIT.
REQ-011 Commands with opcode 6 or 7 (Acquire) SHALL NOT be issued; they SHALL go IDLE -> RSP directly with rsp_mismatch=1.
REQ-012 Expected D opcode: Get(4), Arithmetic(2), Logical(3) -> AccessAckData(1); PutFull(0), PutPartial(1) -> AccessAck(0); Hint(5) -> HintAck(2).
REQ-013 Expected beats SHALL be 2 when the expected opcode is 1 and cmd_size==2, otherwise 1; a 1-bit beats-left counter SHALL track this.
REQ-014 auto_out_d_ready SHALL be 1 only in WAIT; each D fire SHALL decrement beats-left, and the last beat SHALL enter RSP.
REQ-015 The rsp fields SHALL be sticky ORs across all beats: rsp_denied |= d_denied, rsp_corrupt |= d_corrupt; rsp_opcode SHALL be the first beat's opcode.
REQ-016 rsp_mismatch SHALL be set if any beat's opcode differs from the expected opcode or its d_size differs from the captured size.
REQ-017 A timeout counter SHALL clear on WAIT entry and increment each WAIT cycle without a D fire; reaching TIMEOUT_CYCLES SHALL enter RSP with rsp_timeout=1, remaining beats abandoned.
REQ-018 A D fire on the same cycle the counter reaches its limit SHALL count as a beat and SHALL NOT assert timeout.
REQ-019 rsp_valid SHALL be 1 only in RSP, with fields stable; rsp_ready SHALL return to IDLE, and cmd_ready SHALL rise on the following cycle (no IDLE/RSP overlap).
REQ-020 Minimum latency with a_ready=1 and single-beat D the cycle after the A fire: cmd fire at cycle N -> A fire N+1 -> D fire N+2 -> rsp_valid N+3.
REQ-021 A D beat arriving outside WAIT SHALL be ignored (d_ready=0), with no state change.

Reset
REQ-022 reset SHALL force IDLE, beats-left=0, timeout counter=0, and all sticky flags=0.
REQ-023 During and after reset: cmd_ready=1, auto_out_a_valid=0, auto_out_d_ready=0, rsp_valid=0, all rsp fields 0, all A bits 0.
REQ-024 Reset in any state, including mid-burst, SHALL abandon the transaction with no further A or rsp handshake.

Structure
REQ-025 A shared package SHALL hold the TL A/D opcode constants, the FSM state enum, and the expected-response lookup function.
REQ-026 The timeout counter SHALL be sub-module tl_req_timer (inputs clear, enable; output expired), parameterized by TIMEOUT_CYCLES.

Verification
REQ-027 Get size 2 at address 0x1000, with a_ready=1 and D opcode 1 for 2 beats with no flags -> one A fire, 2 D fires, rsp opcode=1 with all flags 0.
REQ-028 PutFull with a_ready low for 5 cycles -> A bits stable throughout, A fires on cycle 6, AccessAck returned, rsp_mismatch=0.
REQ-029 Get, D beat1 corrupt=1 and beat2 denied=1 -> rsp_corrupt=1 and rsp_denied=1.
REQ-030 Hint answered with D opcode 0 -> rsp_mismatch=1; AcquireBlock cmd -> no A fire, rsp_mismatch=1.
REQ-031 TIMEOUT_CYCLES=8, no D -> rsp_timeout=1 exactly 8 cycles after WAIT entry; a D fire on cycle 8 -> no timeout.
REQ-032 Reset asserted after beat 1 of 2 -> next cycle IDLE with outputs per REQ-023; the next Get completes normally.

Source files
------------

// File: rtl/tl_requester_pkg.sv
// ---------------------------------------------------------------------------
// tl_requester_pkg
// Shared definitions for the TileLink requester:
//   - TileLink A-channel and D-channel opcode constants
//   - FSM state encoding (state_t)
//   - expected_d_opcode(): which D opcode answers a given A opcode
//   - is_acquire(): identifies Acquire opcodes that this block never issues
// ---------------------------------------------------------------------------
package tl_requester_pkg;

  // A-channel opcodes
  localparam logic [2:0] A_PUT_FULL      = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL   = 3'd1;
  localparam logic [2:0] A_ARITHMETIC    = 3'd2;
  localparam logic [2:0] A_LOGICAL       = 3'd3;
  localparam logic [2:0] A_GET           = 3'd4;
  localparam logic [2:0] A_HINT          = 3'd5;
  localparam logic [2:0] A_ACQUIRE_BLOCK = 3'd6;
  localparam logic [2:0] A_ACQUIRE_PERM  = 3'd7;

  // D-channel opcodes
  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  // Acquires have no D answer here; they are rejected before issue, so the
  // default arm is never consulted for them.
  function automatic logic [2:0] expected_d_opcode(input logic [2:0] a_opcode);
    logic [2:0] d_op;
    d_op = D_ACCESS_ACK;
    case (a_opcode)
      A_GET, A_ARITHMETIC, A_LOGICAL: d_op = D_ACCESS_ACK_DATA;
      A_PUT_FULL, A_PUT_PARTIAL:      d_op = D_ACCESS_ACK;
      A_HINT:                         d_op = D_HINT_ACK;
      default:                        d_op = D_ACCESS_ACK;
    endcase
    return d_op;
  endfunction

  function automatic logic is_acquire(input logic [2:0] a_opcode);
    return (a_opcode == A_ACQUIRE_BLOCK) || (a_opcode == A_ACQUIRE_PERM);
  endfunction

endpackage

// File: rtl/tl_req_timer.sv
// ---------------------------------------------------------------------------
// tl_req_timer
// Response timeout counter for the requester's WAIT state.
//   clock   : rising-edge clock
//   reset   : synchronous active-high reset, clears the count
//   clear   : clears the count (asserted on the A fire that enters WAIT)
//   enable  : one WAIT cycle elapsed without a D beat
//   expired : this enabled cycle is the TIMEOUT_CYCLES-th one since clear
// expired is combinational from the count and enable so the FSM leaves WAIT
// on exactly the TIMEOUT_CYCLES-th idle cycle. A D beat in that cycle drops
// enable, so a beat on the limit cycle is never reported as a timeout.
// ---------------------------------------------------------------------------
module tl_req_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= 16'd0;
    end else if (enable && !expired) begin
      count <= count + 16'd1;
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/tl_requester.sv
// ---------------------------------------------------------------------------
// tl_requester
// Issues one TileLink A request per command, collects the D response beats
// and reports a summarised result. One transaction outstanding at a time.
//
// Ports:
//   clock, reset                 : rising-edge clock, sync active-high reset
//   cmd_*                        : command handshake (opcode/address/size in)
//   auto_out_a_*                 : TileLink A channel (request out)
//   auto_out_d_*                 : TileLink D channel (response in)
//   rsp_*                        : result handshake (opcode + status flags)
//   dbg_state                    : current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds valid and its payload stable until that edge;
// ready may be asserted independently of valid.
//
// FSM: IDLE -> REQ -> WAIT -> RSP -> IDLE. Acquire commands skip straight
// from IDLE to RSP with rsp_mismatch set. All handshake outputs decode the
// state register only, so none depends combinationally on an input.
// ---------------------------------------------------------------------------
module tl_requester
  import tl_requester_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clock,
  input  logic         reset,

  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_opcode,
  input  logic [127:0] cmd_address,
  input  logic [1:0]   cmd_size,

  output logic         auto_out_a_valid,
  input  logic         auto_out_a_ready,
  output logic [2:0]   auto_out_a_bits_opcode,
  output logic [1:0]   auto_out_a_bits_size,
  output logic [127:0] auto_out_a_bits_address,

  input  logic         auto_out_d_valid,
  output logic         auto_out_d_ready,
  input  logic [2:0]   auto_out_d_bits_opcode,
  input  logic [1:0]   auto_out_d_bits_param,
  input  logic [1:0]   auto_out_d_bits_size,
  input  logic         auto_out_d_bits_denied,
  input  logic         auto_out_d_bits_corrupt,

  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [2:0]   rsp_opcode,
  output logic         rsp_denied,
  output logic         rsp_corrupt,
  output logic         rsp_mismatch,
  output logic         rsp_timeout,

  output state_t       dbg_state
);

  state_t         state;
  logic [2:0]     op_q;
  logic [1:0]     size_q;
  logic [127:0]   addr_q;
  logic [2:0]     exp_op_q;
  logic           beats_left;  // beats still expected after the current one
  logic           first_beat;  // next D beat supplies rsp_opcode
  logic [2:0]     rsp_opcode_q;
  logic           denied_q;
  logic           corrupt_q;
  logic           mismatch_q;
  logic           timeout_q;

  logic           a_fire;
  logic           d_fire;
  logic           timer_expired;
  logic [2:0]     cmd_exp_op;

  // The D param field carries nothing this requester acts on.
  logic           unused_param;
  assign unused_param = ^auto_out_d_bits_param;

  assign a_fire     = (state == ST_REQ) && auto_out_a_ready;
  assign d_fire     = (state == ST_WAIT) && auto_out_d_valid;
  assign cmd_exp_op = expected_d_opcode(cmd_opcode);

  tl_req_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (a_fire),
    .enable  ((state == ST_WAIT) && !d_fire),
    .expired (timer_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      op_q         <= 3'd0;
      size_q       <= 2'd0;
      addr_q       <= 128'd0;
      exp_op_q     <= 3'd0;
      beats_left   <= 1'b0;
      first_beat   <= 1'b0;
      rsp_opcode_q <= 3'd0;
      denied_q     <= 1'b0;
      corrupt_q    <= 1'b0;
      mismatch_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q         <= cmd_opcode;
            size_q       <= cmd_size;
            addr_q       <= cmd_address;
            exp_op_q     <= cmd_exp_op;
            // Only a 2-beat AccessAckData burst needs a second beat.
            beats_left   <= (cmd_exp_op == D_ACCESS_ACK_DATA) && (cmd_size == 2'd2);
            first_beat   <= 1'b1;
            rsp_opcode_q <= 3'd0;
            denied_q     <= 1'b0;
            corrupt_q    <= 1'b0;
            timeout_q    <= 1'b0;
            if (is_acquire(cmd_opcode)) begin
              mismatch_q <= 1'b1;
              state      <= ST_RSP;
            end else begin
              mismatch_q <= 1'b0;
              state      <= ST_REQ;
            end
          end
        end

        ST_REQ: begin
          if (auto_out_a_ready) begin
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (d_fire) begin
            first_beat <= 1'b0;
            if (first_beat) begin
              rsp_opcode_q <= auto_out_d_bits_opcode;
            end
            denied_q   <= denied_q  | auto_out_d_bits_denied;
            corrupt_q  <= corrupt_q | auto_out_d_bits_corrupt;
            mismatch_q <= mismatch_q
                        | (auto_out_d_bits_opcode != exp_op_q)
                        | (auto_out_d_bits_size   != size_q);
            if (beats_left) begin
              beats_left <= 1'b0;
            end else begin
              state <= ST_RSP;
            end
          end else if (timer_expired) begin
            timeout_q  <= 1'b1;
            beats_left <= 1'b0;
            state      <= ST_RSP;
          end
        end

        ST_RSP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready               = (state == ST_IDLE);
  assign auto_out_a_valid        = (state == ST_REQ);
  assign auto_out_d_ready        = (state == ST_WAIT);
  assign rsp_valid               = (state == ST_RSP);

  assign auto_out_a_bits_opcode  = op_q;
  assign auto_out_a_bits_size    = size_q;
  assign auto_out_a_bits_address = addr_q;

  assign rsp_opcode              = rsp_opcode_q;
  assign rsp_denied              = denied_q;
  assign rsp_corrupt             = corrupt_q;
  assign rsp_mismatch            = mismatch_q;
  assign rsp_timeout             = timeout_q;

  assign dbg_state               = state;

endmodule

// File: tb/tb_tl_requester.sv
// ---------------------------------------------------------------------------
// tb_tl_requester
// Directed testbench for tl_requester (TIMEOUT_CYCLES = 8). Inputs change and
// outputs are sampled on the falling clock edge; the DUT acts on the rising
// edge between them.
// ---------------------------------------------------------------------------
module tb_tl_requester;
  import tl_requester_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_opcode;
  logic [127:0] cmd_address;
  logic [1:0]   cmd_size;
  logic         a_valid;
  logic         a_ready;
  logic [2:0]   a_opcode;
  logic [1:0]   a_size;
  logic [127:0] a_address;
  logic         d_valid;
  logic         d_ready;
  logic [2:0]   d_opcode;
  logic [1:0]   d_param;
  logic [1:0]   d_size;
  logic         d_denied;
  logic         d_corrupt;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [2:0]   rsp_opcode;
  logic         rsp_denied;
  logic         rsp_corrupt;
  logic         rsp_mismatch;
  logic         rsp_timeout;
  state_t       dbg_state;

  int checks = 0;
  int errors = 0;
  int a_fires = 0;
  int d_fires = 0;
  int rsp_fires = 0;

  tl_requester #(.TIMEOUT_CYCLES(8)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_opcode              (cmd_opcode),
    .cmd_address             (cmd_address),
    .cmd_size                (cmd_size),
    .auto_out_a_valid        (a_valid),
    .auto_out_a_ready        (a_ready),
    .auto_out_a_bits_opcode  (a_opcode),
    .auto_out_a_bits_size    (a_size),
    .auto_out_a_bits_address (a_address),
    .auto_out_d_valid        (d_valid),
    .auto_out_d_ready        (d_ready),
    .auto_out_d_bits_opcode  (d_opcode),
    .auto_out_d_bits_param   (d_param),
    .auto_out_d_bits_size    (d_size),
    .auto_out_d_bits_denied  (d_denied),
    .auto_out_d_bits_corrupt (d_corrupt),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_opcode              (rsp_opcode),
    .rsp_denied              (rsp_denied),
    .rsp_corrupt             (rsp_corrupt),
    .rsp_mismatch            (rsp_mismatch),
    .rsp_timeout             (rsp_timeout),
    .dbg_state               (dbg_state)
  );

  // Handshake counters, outside reset only.
  always @(posedge clock) begin
    if (!reset) begin
      if (a_valid && a_ready)     a_fires++;
      if (d_valid && d_ready)     d_fires++;
      if (rsp_valid && rsp_ready) rsp_fires++;
    end
  end

  // ---------------- scoreboard check ----------------
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue_cmd(input logic [2:0] op, input logic [127:0] addr, input logic [1:0] sz);
    int budget = 0;
    while (!cmd_ready && budget < 20) begin
      @(negedge clock);
      budget++;
    end
    check_eq("cmd_ready_wait", {127'd0, cmd_ready}, 128'd1);
    cmd_valid   = 1'b1;
    cmd_opcode  = op;
    cmd_address = addr;
    cmd_size    = sz;
    @(negedge clock);
    cmd_valid   = 1'b0;
    cmd_opcode  = 3'd0;
    cmd_address = 128'd0;
    cmd_size    = 2'd0;
  endtask

  // Holds a_ready low for 'stall' REQ cycles, then accepts the request.
  task automatic a_phase(input int stall, input logic [2:0] op, input logic [127:0] addr,
                         input logic [1:0] sz);
    a_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      check_eq("a_valid_stall", {127'd0, a_valid}, 128'd1);
      check_eq("a_addr_stall", a_address, addr);
      check_eq("a_op_size_stall", {123'd0, a_opcode, a_size}, {123'd0, op, sz});
      @(negedge clock);
    end
    a_ready = 1'b1;
    check_eq("a_valid", {127'd0, a_valid}, 128'd1);
    check_eq("a_addr", a_address, addr);
    check_eq("a_op_size", {123'd0, a_opcode, a_size}, {123'd0, op, sz});
    @(negedge clock);
  endtask

  task automatic d_beat(input logic [2:0] op, input logic [1:0] sz, input logic den,
                        input logic cor);
    d_valid   = 1'b1;
    d_opcode  = op;
    d_size    = sz;
    d_param   = 2'd0;
    d_denied  = den;
    d_corrupt = cor;
    check_eq("d_ready", {127'd0, d_ready}, 128'd1);
    @(negedge clock);
    d_valid   = 1'b0;
    d_opcode  = 3'd0;
    d_size    = 2'd0;
    d_denied  = 1'b0;
    d_corrupt = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic [2:0] op, input logic den,
                           input logic cor, input logic mm, input logic to);
    check_eq({tag, "_valid"}, {127'd0, rsp_valid}, 128'd1);
    check_eq({tag, "_cmd_ready"}, {127'd0, cmd_ready}, 128'd0);
    check_eq({tag, "_fields"},
             {121'd0, rsp_opcode, rsp_denied, rsp_corrupt, rsp_mismatch, rsp_timeout},
             {121'd0, op, den, cor, mm, to});
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check_eq({tag, "_rsp_drop"}, {127'd0, rsp_valid}, 128'd0);
    check_eq({tag, "_idle_ready"}, {127'd0, cmd_ready}, 128'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, {127'd0, cmd_ready}, 128'd1);
    check_eq({tag, "_a_d_rsp_valid"}, {125'd0, a_valid, d_ready, rsp_valid}, 128'd0);
    check_eq({tag, "_rsp_fields"},
             {121'd0, rsp_opcode, rsp_denied, rsp_corrupt, rsp_mismatch, rsp_timeout}, 128'd0);
    check_eq({tag, "_a_addr"}, a_address, 128'd0);
    check_eq({tag, "_a_op_size"}, {123'd0, a_opcode, a_size}, 128'd0);
    check_eq({tag, "_state"}, {126'd0, dbg_state}, {126'd0, ST_IDLE});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a0;
    int d0;
    int r0;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_opcode = 3'd0; cmd_address = 128'd0; cmd_size = 2'd0;
    a_ready = 1'b1;
    d_valid = 1'b0; d_opcode = 3'd0; d_param = 2'd0; d_size = 2'd0;
    d_denied = 1'b0; d_corrupt = 1'b0;
    rsp_ready = 1'b0;

    repeat (3) @(negedge clock);
    check_reset_outputs("in_reset");
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("after_reset");

    // Minimum latency: cmd N, A N+1, D N+2, rsp_valid N+3.
    issue_cmd(A_GET, 128'h40, 2'd0);
    a_phase(0, A_GET, 128'h40, 2'd0);
    d_beat(D_ACCESS_ACK_DATA, 2'd0, 1'b0, 1'b0);
    check_rsp("latency", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    finish_rsp("latency");

    // Get size 2 at 0x1000, two clean beats.
    a0 = a_fires; d0 = d_fires;
    issue_cmd(A_GET, 128'h1000, 2'd2);
    a_phase(0, A_GET, 128'h1000, 2'd2);
    d_beat(D_ACCESS_ACK_DATA, 2'd2, 1'b0, 1'b0);
    check_eq("get2_mid_no_rsp", {127'd0, rsp_valid}, 128'd0);
    d_beat(D_ACCESS_ACK_DATA, 2'd2, 1'b0, 1'b0);
    check_rsp("get2", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("get2_a_fires", 128'(a_fires - a0), 128'd1);
    check_eq("get2_d_fires", 128'(d_fires - d0), 128'd2);
    finish_rsp("get2");

    // PutFull with a_ready low for 5 cycles.
    a0 = a_fires;
    issue_cmd(A_PUT_FULL, 128'h2000_0000_0000_0000_0000_0000_0000_2000, 2'd1);
    a_phase(5, A_PUT_FULL, 128'h2000_0000_0000_0000_0000_0000_0000_2000, 2'd1);
    check_eq("put_a_fires", 128'(a_fires - a0), 128'd1);
    d_beat(D_ACCESS_ACK, 2'd1, 1'b0, 1'b0);
    check_rsp("put", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    finish_rsp("put");

    // Get: beat 1 corrupt, beat 2 denied -> both sticky flags set.
    issue_cmd(A_GET, 128'h3000, 2'd2);
    a_phase(0, A_GET, 128'h3000, 2'd2);
    d_beat(D_ACCESS_ACK_DATA, 2'd2, 1'b0, 1'b1);
    d_beat(D_ACCESS_ACK_DATA, 2'd2, 1'b1, 1'b0);
    check_rsp("flags", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    finish_rsp("flags");

    // Hint answered with AccessAck -> mismatch.
    issue_cmd(A_HINT, 128'h3100, 2'd0);
    a_phase(0, A_HINT, 128'h3100, 2'd0);
    d_beat(D_ACCESS_ACK, 2'd0, 1'b0, 1'b0);
    check_rsp("hint", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    finish_rsp("hint");

    // AcquireBlock: no A fire, straight to response with mismatch.
    a0 = a_fires;
    issue_cmd(A_ACQUIRE_BLOCK, 128'h4000, 2'd2);
    check_eq("acq_a_valid", {127'd0, a_valid}, 128'd0);
    check_rsp("acq", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    finish_rsp("acq");
    check_eq("acq_a_fires", 128'(a_fires - a0), 128'd0);

    // Logical size 2: rsp_opcode from beat 1, wrong beat-2 opcode -> mismatch.
    issue_cmd(A_LOGICAL, 128'h4100, 2'd2);
    a_phase(0, A_LOGICAL, 128'h4100, 2'd2);
    d_beat(D_ACCESS_ACK_DATA, 2'd2, 1'b0, 1'b0);
    d_beat(D_ACCESS_ACK, 2'd2, 1'b0, 1'b0);
    check_rsp("logical", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    finish_rsp("logical");

    // PutPartial answered with the wrong size -> mismatch.
    issue_cmd(A_PUT_PARTIAL, 128'h4200, 2'd1);
    a_phase(0, A_PUT_PARTIAL, 128'h4200, 2'd1);
    d_beat(D_ACCESS_ACK, 2'd0, 1'b0, 1'b0);
    check_rsp("size_mm", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    finish_rsp("size_mm");

    // Timeout: no D; response exactly 8 cycles after WAIT entry.
    issue_cmd(A_GET, 128'h5000, 2'd0);
    a_phase(0, A_GET, 128'h5000, 2'd0);
    repeat (7) @(negedge clock);
    check_eq("to_wait_cycle8", {126'd0, dbg_state}, {126'd0, ST_WAIT});
    @(negedge clock);
    check_rsp("to", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    finish_rsp("to");

    // D fire on the 8th WAIT cycle counts as a beat, no timeout.
    issue_cmd(A_GET, 128'h5040, 2'd0);
    a_phase(0, A_GET, 128'h5040, 2'd0);
    repeat (7) @(negedge clock);
    d_beat(D_ACCESS_ACK_DATA, 2'd0, 1'b0, 1'b0);
    check_rsp("to_edge", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    finish_rsp("to_edge");

    // D beat in IDLE is ignored.
    d0 = d_fires;
    d_valid = 1'b1; d_opcode = D_ACCESS_ACK_DATA;
    check_eq("idle_d_ready", {127'd0, d_ready}, 128'd0);
    @(negedge clock);
    d_valid = 1'b0; d_opcode = 3'd0;
    check_eq("idle_d_state", {126'd0, dbg_state}, {126'd0, ST_IDLE});
    check_eq("idle_d_fires", 128'(d_fires - d0), 128'd0);

    // Reset after beat 1 of 2 abandons the burst.
    issue_cmd(A_GET, 128'h6000, 2'd2);
    a_phase(0, A_GET, 128'h6000, 2'd2);
    d_beat(D_ACCESS_ACK_DATA, 2'd2, 1'b1, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    a0 = a_fires; r0 = rsp_fires;
    repeat (3) @(negedge clock);
    check_eq("post_reset_quiet", {96'd0, 32'(a_fires - a0), 32'(rsp_fires - r0)}, 128'd0);
    check_reset_outputs("post_reset");

    issue_cmd(A_GET, 128'h7000, 2'd2);
    a_phase(0, A_GET, 128'h7000, 2'd2);
    d_beat(D_ACCESS_ACK_DATA, 2'd2, 1'b0, 1'b0);
    d_beat(D_ACCESS_ACK_DATA, 2'd2, 1'b0, 1'b0);
    check_rsp("recover", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    finish_rsp("recover");

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Run-time bound.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
